pio_pwm_bank: RTL and testbench

Four-channel 8-bit PWM generator driven by the 32-bit output word of the Nios II output PIO. It sits directly downstream of the PIO: the PIO's `out_port` feeds `pio_word`, and `pwm_out` drives board LEDs or external pins. Software sets four duty cycles with a single PIO write. The block runs a shared prescaled period counter and produces registered, glitch-free PWM outputs.

---
 rtl/pio_pwm_pkg.sv | 8 +
 rtl/pio_pwm_channel.sv | 35 +++
 rtl/pio_pwm_bank.sv | 51 +++++
 tb/tb_pio_pwm_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pio_pwm_pkg.sv
// pio_pwm_pkg: shared widths, limits and duty types for the PIO-driven PWM bank
package pio_pwm_pkg;
  localparam int DUTY_W = 8;
  localparam int NUM_CH = 4;
  localparam logic [DUTY_W-1:0] STEP_MAX = 8'd255;
  typedef logic [DUTY_W-1:0] duty_t;
  typedef duty_t [NUM_CH-1:0] duty_vec_t;
endpackage

// File: rtl/pio_pwm_channel.sv
// pio_pwm_channel: one PWM lane (duty register, step compare, output flop); PIO_PWM_SYNC_UPDATE_EN selects wrap-only duty load
module pio_pwm_channel
  import pio_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  duty_t duty_in,
  input  duty_t step,
  input  logic  wrap,
  output logic  pwm
);
`ifdef PIO_PWM_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  duty_t duty_active_q, duty_active_d;
  logic  pwm_q, pwm_d;
  // duty reloads only at the period boundary when synchronised, otherwise every cycle
  always_comb begin
    duty_active_d = (wrap || !SYNC) ? duty_in : duty_active_q;
    pwm_d         = step < duty_active_q;
  end
  // duty register and glitch-free output flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_active_q <= '0;
      pwm_q         <= 1'b0;
    end else begin
      duty_active_q <= duty_active_d;
      pwm_q         <= pwm_d;
    end
  end
  assign pwm = pwm_q;
endmodule

// File: rtl/pio_pwm_bank.sv
// pio_pwm_bank: four 8-bit PWM channels fed by a 32-bit PIO word; PIO_PWM_SYNC_UPDATE_EN defers duty updates to period wrap
module pio_pwm_bank
  import pio_pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 50,
  parameter int unsigned DUTY_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DUTY_W-1:0] pio_word,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     period_start
);
  logic [15:0]       presc_q, presc_d;
  logic [DUTY_W-1:0] step_q, step_d;
  logic              period_start_q, period_start_d;
  logic              tick, wrap;
  duty_vec_t         duty_vec;
  assign duty_vec = duty_vec_t'(pio_word);
  // prescaler and step counter advance, wrap detection
  always_comb begin
    tick           = presc_q == 16'(PRESCALE - 1);
    wrap           = tick && (step_q == STEP_MAX);
    presc_d        = tick ? '0 : presc_q + 16'd1;
    step_d         = tick ? step_q + DUTY_W'(1) : step_q;
    period_start_d = wrap;
  end
  // shared timebase registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q        <= '0;
      step_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      step_q         <= step_d;
      period_start_q <= period_start_d;
    end
  end
  assign period_start = period_start_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pio_pwm_channel u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .duty_in (duty_vec[i]),
      .step    (step_q),
      .wrap    (wrap),
      .pwm     (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pio_pwm_bank.sv
// tb_pio_pwm_bank: directed checks of reset, duty sweep, mid-period update, PRESCALE=1 and mid-period reset
module tb_pio_pwm_bank;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reset_n1 = 1'b0;
  logic [31:0] pio_word = '0;
  logic [31:0] pio_word1 = '0;
  logic [3:0]  pwm_out, pwm_out1;
  logic        period_start, period_start1;
  int          vectors = 0;
  int          miscompares = 0;
`ifdef PIO_PWM_SYNC_UPDATE_EN
  localparam int EXP_HI1 = 256;
  localparam logic EXP_P202 = 1'b1;
`else
  localparam int EXP_HI1 = 201;
  localparam logic EXP_P202 = 1'b0;
`endif

  pio_pwm_bank #(.PRESCALE(2)) dut (
    .clk(clk), .reset_n(reset_n), .pio_word(pio_word),
    .pwm_out(pwm_out), .period_start(period_start)
  );
  pio_pwm_bank #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n1), .pio_word(pio_word1),
    .pwm_out(pwm_out1), .period_start(period_start1)
  );

  always #5 clk = ~clk;

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!period_start && n < 3000);
  endtask

  task automatic wait_ps1(output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!period_start1 && n < 3000);
  endtask

  task automatic test_reset;
    int n;
    reset_n = 1'b0;
    pio_word = 32'hFFFF_FFFF;
    repeat (3) step_clk();
    vectors++;
    if (pwm_out !== 4'h0) begin miscompares++; $display("FAIL reset_pwm: got %h expected 0", pwm_out); end
    vectors++;
    if (period_start !== 1'b0) begin miscompares++; $display("FAIL reset_ps: got %b expected 0", period_start); end
    reset_n = 1'b1;
    wait_ps(n);
    vectors++;
    if (n !== 512) begin miscompares++; $display("FAIL first_period_start: got %0d expected 512", n); end
  endtask

  task automatic test_duty_sweep;
    int n;
    int hi [4];
    pio_word = 32'h0040_80FF;
    wait_ps(n);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int k = 1; k <= 512; k++) begin
      step_clk();
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
    end
    vectors++;
    if (hi[0] !== 510) begin miscompares++; $display("FAIL sweep_ch0: got %0d expected 510", hi[0]); end
    vectors++;
    if (hi[1] !== 256) begin miscompares++; $display("FAIL sweep_ch1: got %0d expected 256", hi[1]); end
    vectors++;
    if (hi[2] !== 128) begin miscompares++; $display("FAIL sweep_ch2: got %0d expected 128", hi[2]); end
    vectors++;
    if (hi[3] !== 0) begin miscompares++; $display("FAIL sweep_ch3: got %0d expected 0", hi[3]); end
  endtask

  task automatic test_mid_change;
    int   n, hi1, hi2;
    logic p202, p512, p513, ps512;
    logic [2:0] oth;
    hi1 = 0; hi2 = 0; oth = '0;
    p202 = 1'bx; p512 = 1'bx; p513 = 1'bx; ps512 = 1'bx;
    pio_word = 32'h0000_0080;
    wait_ps(n);
    for (int k = 1; k <= 1024; k++) begin
      step_clk();
      if (k == 200) pio_word = 32'h0000_0010;
      if (k <= 512) hi1 += int'(pwm_out[0]);
      else hi2 += int'(pwm_out[0]);
      oth |= pwm_out[3:1];
      if (k == 202) p202 = pwm_out[0];
      if (k == 512) begin p512 = pwm_out[0]; ps512 = period_start; end
      if (k == 513) p513 = pwm_out[0];
    end
    vectors++;
    if (hi1 !== EXP_HI1) begin miscompares++; $display("FAIL change_hi_cur: got %0d expected %0d", hi1, EXP_HI1); end
    vectors++;
    if (p202 !== EXP_P202) begin miscompares++; $display("FAIL change_pwm_k202: got %b expected %b", p202, EXP_P202); end
    vectors++;
    if (ps512 !== 1'b1) begin miscompares++; $display("FAIL change_ps_k512: got %b expected 1", ps512); end
    vectors++;
    if (p512 !== 1'b0) begin miscompares++; $display("FAIL change_pwm_k512: got %b expected 0", p512); end
    vectors++;
    if (p513 !== 1'b1) begin miscompares++; $display("FAIL change_pwm_k513: got %b expected 1", p513); end
    vectors++;
    if (hi2 !== 32) begin miscompares++; $display("FAIL change_hi_next: got %0d expected 32", hi2); end
    vectors++;
    if (oth !== 3'b000) begin miscompares++; $display("FAIL change_other_ch: got %b expected 000", oth); end
  endtask

  task automatic test_prescale1;
    int   n, hi, ps;
    logic p1;
    hi = 0; ps = 0; p1 = 1'bx;
    pio_word1 = 32'h0000_0001;
    reset_n1 = 1'b1;
    wait_ps1(n);
    vectors++;
    if (n !== 256) begin miscompares++; $display("FAIL p1_first_ps: got %0d expected 256", n); end
    for (int k = 1; k <= 512; k++) begin
      step_clk();
      hi += int'(pwm_out1[0]);
      ps += int'(period_start1);
      if (k == 1) p1 = pwm_out1[0];
    end
    vectors++;
    if (hi !== 2) begin miscompares++; $display("FAIL p1_high_count: got %0d expected 2", hi); end
    vectors++;
    if (ps !== 2) begin miscompares++; $display("FAIL p1_ps_count: got %0d expected 2", ps); end
    vectors++;
    if (p1 !== 1'b1) begin miscompares++; $display("FAIL p1_pulse_pos: got %b expected 1", p1); end
  endtask

  task automatic test_reset_mid;
    int n, hi;
    hi = 0;
    pio_word = 32'h0000_00FF;
    wait_ps(n);
    repeat (274) step_clk();
    vectors++;
    if (pwm_out[0] !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: got %b expected 1", pwm_out[0]); end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (pwm_out !== 4'h0) begin miscompares++; $display("FAIL rmid_async_pwm: got %h expected 0", pwm_out); end
    vectors++;
    if (period_start !== 1'b0) begin miscompares++; $display("FAIL rmid_async_ps: got %b expected 0", period_start); end
    repeat (3) step_clk();
    reset_n = 1'b1;
    wait_ps(n);
    vectors++;
    if (n !== 512) begin miscompares++; $display("FAIL rmid_restart: got %0d expected 512", n); end
    for (int k = 1; k <= 512; k++) begin
      step_clk();
      hi += int'(pwm_out[0]);
    end
    vectors++;
    if (hi !== 510) begin miscompares++; $display("FAIL rmid_full_period: got %0d expected 510", hi); end
  endtask

  initial begin
    test_reset();
    test_duty_sweep();
    test_mid_change();
    test_prescale1();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
